gf8_divider: RTL and testbench

//  Sequential GF(2^8) divider: quotient = A / B = A * B^254 (mod POLY).

---
 rtl/gf8_divider.sv | 140 ++++++++++++++
 tb/tb_gf8_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gf8_divider.sv
// Sequential GF(2^8) divider: quotient = A * B^254 mod POLY, square-and-multiply on one shared multiplier.
// Latency: fixed 17 cycles from accept edge to out_valid (8 x SQR/MUL + FINAL), independent of data.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready, then one idle cycle.
module gf8_divider #(
   parameter logic [8:0] POLY = 9'h11B
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] quotient,
   output logic       div_by_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQR,
      S_MUL,
      S_FINAL,
      S_DONE
   } state_t;

   // B^254: 254 = 8'b1111_1110, scanned MSB first
   localparam logic [7:0] EXP = 8'hFE;

   state_t     state_q, state_d;
   logic [7:0] r_q, r_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] quot_q, quot_d;
   logic       dbz_q, dbz_d;
   logic       ov_q, ov_d;

   logic [7:0] mul_x, mul_y, mul_p;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ ({7'b0, x} << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ ({6'b0, POLY} << (i - 8));
      end
      return p[7:0];
   endfunction

   always_comb begin
      mul_x = r_q;
      mul_y = r_q;
      case (state_q)
         S_MUL:   mul_y = b_q;
         S_FINAL: mul_y = a_q;
         default: mul_y = r_q;
      endcase
   end

   assign mul_p = gf_mul(mul_x, mul_y);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      quot_d  = quot_q;
      dbz_d   = dbz_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               r_d     = 8'h01;
               idx_d   = 3'd7;
               dbz_d   = (B == 8'h00);
               state_d = S_SQR;
            end
         end
         S_SQR: begin
            r_d     = mul_p;
            state_d = S_MUL;
         end
         S_MUL: begin
            if (EXP[idx_q]) r_d = mul_p;
            if (idx_q == 3'd0) begin
               state_d = S_FINAL;
            end else begin
               idx_d   = idx_q - 3'd1;
               state_d = S_SQR;
            end
         end
         S_FINAL: begin
            quot_d  = mul_p;
            ov_d    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         r_q     <= 8'h01;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         idx_q   <= 3'd7;
         quot_q  <= 8'h00;
         dbz_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         quot_q  <= quot_d;
         dbz_q   <= dbz_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = ov_q;
   assign quotient    = quot_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf8_divider.sv
// Directed bench for gf8_divider: known quotients, latency, backpressure, reset abort, random inverse property.
module tb_gf8_divider;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic       div_by_zero;

   int errors = 0;
   int checks = 0;

   gf8_divider #(.POLY(9'h11B)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Shift-and-xtime multiply, structured differently from a carry-less product + reduction
   function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] a, b, p;
      a = x;
      b = y;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         b = {1'b0, b[7:1]};
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one division, wait for out_valid, leave the result pending in DONE
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic dbz, output int lat);
      @(negedge clk);
      check("accept_rdy", in_ready, 1);
      in_valid = 1'b1;
      A = a;
      B = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      A = ~a;
      B = ~b;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      q   = quotient;
      dbz = div_by_zero;
   endtask

   task automatic handshake(input logic [7:0] exp_q);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_out_valid", out_valid, 0);
      check("hs_in_ready", in_ready, 1);
      check("hs_q_hold", quotient, exp_q);
   endtask

   logic [7:0] q;
   logic       dbz;
   int         lat;
   int         seen;
   logic [7:0] ra, rb;

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = 8'h00;
      B         = 8'h00;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 8'h00);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      reset = 1'b1;

      // 1 / 0x53 = 0xCA
      do_op(8'h01, 8'h53, q, dbz, lat);
      check("t1_lat", lat, 17);
      check("t1_q", q, 8'hCA);
      check("t1_dbz", dbz, 0);
      handshake(8'hCA);

      do_op(8'hCA, 8'hCA, q, dbz, lat);
      check("t2a_q", q, 8'h01);
      check("t2a_dbz", dbz, 0);
      handshake(8'h01);

      // Divide by zero: same latency, zero quotient, flag set
      do_op(8'h53, 8'h00, q, dbz, lat);
      check("t3_lat", lat, 17);
      check("t3_q", q, 8'h00);
      check("t3_dbz", dbz, 1);
      handshake(8'h00);

      do_op(8'h00, 8'h53, q, dbz, lat);
      check("t3b_q", q, 8'h00);
      check("t3b_dbz", dbz, 0);
      handshake(8'h00);

      // Backpressure: result held for 10 cycles, in_valid pulses ignored
      do_op(8'h57, 8'h01, q, dbz, lat);
      check("t2b_q", q, 8'h57);
      check("t2b_lat", lat, 17);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         A = 8'hFF;
         B = 8'h03;
         @(posedge clk);
         @(negedge clk);
         check("t4_ov_hold", out_valid, 1);
         check("t4_q_hold", quotient, 8'h57);
         check("t4_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      handshake(8'h57);
      do_op(8'h03, 8'h03, q, dbz, lat);
      check("t4_next_q", q, 8'h01);
      check("t4_next_lat", lat, 17);
      handshake(8'h01);

      // Reset in the middle of an operation
      @(negedge clk);
      in_valid = 1'b1;
      A = 8'h0E;
      B = 8'h09;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_ov", out_valid, 0);
      check("t5_rdy", in_ready, 1);
      check("t5_q", quotient, 8'h00);
      check("t5_dbz", div_by_zero, 0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("t5_no_pulse", seen, 0);
      do_op(8'h02, 8'h02, q, dbz, lat);
      check("t5_next_q", q, 8'h01);
      check("t5_next_lat", lat, 17);
      handshake(8'h01);

      // Random pairs: quotient * B must recover A
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         do_op(ra, rb, q, dbz, lat);
         check("t6_inverse", ref_mul(q, rb), ra);
         check("t6_dbz", dbz, 0);
         handshake(q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
